// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
package axi_lite_reg_slave_pkg;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 8;
  localparam int BUFFER_SIZE = 4096;
  localparam int ID_OFFSET   = 0;

  typedef logic [ADDR_W-1:0]               addr_t;
  typedef logic [DATA_W-1:0]               data_t;
  typedef logic                            strb_t;
  typedef logic [1:0]                      resp_t;
  typedef logic [$clog2(BUFFER_SIZE)-1:0]  reg_idx_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP
  } state_type;

  typedef struct packed {
    addr_t ar_addr;
    logic  ar_valid;
    logic  r_ready;
    addr_t aw_addr;
    logic  aw_valid;
    data_t w_data;
    strb_t w_strb;
    logic  w_valid;
    logic  b_ready;
  } axi_lite_bus_t;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite channel bundle between interconnect (master) and register slave.
interface axi_lite_reg_slave_if;
  import axi_lite_reg_slave_pkg::*;

  addr_t ar_addr;
  logic  ar_valid;
  logic  ar_ready;
  data_t r_data;
  resp_t r_resp;
  logic  r_valid;
  logic  r_ready;
  addr_t aw_addr;
  logic  aw_valid;
  logic  aw_ready;
  data_t w_data;
  strb_t w_strb;
  logic  w_valid;
  logic  w_ready;
  resp_t b_resp;
  logic  b_valid;
  logic  b_ready;

  modport slave (
    input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid,
    input  w_data, w_strb, w_valid, b_ready,
    output ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready,
    output b_resp, b_valid
  );

  modport master (
    output ar_addr, ar_valid, r_ready, aw_addr, aw_valid,
    output w_data, w_strb, w_valid, b_ready,
    input  ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready,
    input  b_resp, b_valid
  );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// Window decode shared by read and write paths; offset wraps modulo 4096,
// so addresses below the base land high and miss.
module axi_lite_addr_decode
  import axi_lite_reg_slave_pkg::*;
#(
  parameter addr_t BASE_ADDR = 12'h000,
  parameter int    NUM_REGS  = 16
) (
  input  addr_t    i_addr,
  input  logic     i_is_write,
  output logic     o_hit,
  output reg_idx_t o_offset,
  output resp_t    o_resp
);

  localparam reg_idx_t LIMIT = reg_idx_t'(NUM_REGS);

  always_comb begin
    o_offset = reg_idx_t'(i_addr - BASE_ADDR);
    o_hit    = (o_offset < LIMIT);
    if (!o_hit)
      o_resp = RESP_DECERR;
    else if (i_is_write && (o_offset == reg_idx_t'(ID_OFFSET)))
      o_resp = RESP_SLVERR;
    else
      o_resp = RESP_OKAY;
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave: one transaction at a time into a window of 8-bit registers,
// register 0 is a read-only ID.
module axi_lite_reg_slave
  import axi_lite_reg_slave_pkg::*;
#(
  parameter addr_t BASE_ADDR = 12'h000,
  parameter int    NUM_REGS  = 16,
  parameter data_t ID_VALUE  = 8'hA5
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  axi_lite_reg_slave_if.slave  axi
);

  state_type r_state;
  state_type w_next;
  logic      r_last_rd;
  addr_t     r_waddr;
  data_t     r_rdata;
  resp_t     r_rresp;
  resp_t     r_bresp;
  data_t     r_regs [NUM_REGS];

  logic      w_ar_hs;
  logic      w_aw_hs;
  logic      w_w_hs;
  addr_t     w_dec_addr;
  logic      w_dec_is_write;
  logic      w_hit;
  reg_idx_t  w_off;
  resp_t     w_dec_resp;
  data_t     w_rd_data;

  assign w_ar_hs = (r_state == RADDR) && axi.ar_valid;
  assign w_aw_hs = (r_state == WADDR) && axi.aw_valid;
  assign w_w_hs  = (r_state == WDATA) && axi.w_valid;

  // The decoder sees the live AR address while in RADDR and the latched AW address otherwise.
  assign w_dec_addr     = (r_state == RADDR) ? axi.ar_addr : r_waddr;
  assign w_dec_is_write = (r_state != RADDR);

  axi_lite_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .i_addr     (w_dec_addr),
    .i_is_write (w_dec_is_write),
    .o_hit      (w_hit),
    .o_offset   (w_off),
    .o_resp     (w_dec_resp)
  );

  always_comb begin
    w_rd_data = '0;
    if (w_hit) begin
      if (w_off == reg_idx_t'(ID_OFFSET)) begin
        w_rd_data = ID_VALUE;
      end else begin
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
          if (w_off == reg_idx_t'(i)) w_rd_data = r_regs[i];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (axi.ar_valid && axi.aw_valid) w_next = r_last_rd ? WADDR : RADDR;
        else if (axi.ar_valid)            w_next = RADDR;
        else if (axi.aw_valid)            w_next = WADDR;
      end
      RADDR:   if (w_ar_hs)       w_next = RDATA;
      RDATA:   if (axi.r_ready)   w_next = IDLE;
      WADDR:   if (w_aw_hs)       w_next = WDATA;
      WDATA:   if (w_w_hs)        w_next = WRESP;
      WRESP:   if (axi.b_ready)   w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_comb begin
    axi.ar_ready = 1'b0;
    axi.r_valid  = 1'b0;
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    case (r_state)
      RADDR:   axi.ar_ready = 1'b1;
      RDATA:   axi.r_valid  = 1'b1;
      WADDR:   axi.aw_ready = 1'b1;
      WDATA:   axi.w_ready  = 1'b1;
      WRESP:   axi.b_valid  = 1'b1;
      default: ;
    endcase
  end

  assign axi.r_data = r_rdata;
  assign axi.r_resp = r_rresp;
  assign axi.b_resp = r_bresp;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_last_rd <= 1'b0;
      r_waddr   <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_bresp   <= RESP_OKAY;
      for (int unsigned i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rdata   <= w_rd_data;
        r_rresp   <= w_dec_resp;
        r_last_rd <= 1'b1;
      end
      if (w_aw_hs) begin
        r_waddr   <= axi.aw_addr;
        r_last_rd <= 1'b0;
      end
      if (w_w_hs) begin
        r_bresp <= w_dec_resp;
        // Offset 0 never matches here, so the ID register stays read-only.
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
          if ((w_off == reg_idx_t'(i)) && axi.w_strb) r_regs[i] <= axi.w_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a response scoreboard and a reference register model.
module tb_axi_lite_reg_slave;
  import axi_lite_reg_slave_pkg::*;

  localparam logic [11:0] T_BASE = 12'h000;
  localparam int          T_NUM  = 16;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_reg_slave_if bus();

  axi_lite_reg_slave #(
    .BASE_ADDR (T_BASE),
    .NUM_REGS  (T_NUM),
    .ID_VALUE  (8'hA5)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .axi      (bus)
  );

  typedef struct {
    string       tag;
    logic [7:0]  data;
    logic [1:0]  resp;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_regs [T_NUM];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < T_NUM; i++) m_regs[i] = 8'h00;
  endfunction

  function automatic void model_rd(input logic [11:0] a, output logic [7:0] d, output logic [1:0] r);
    logic [11:0] off;
    off = a - T_BASE;
    if (off >= 12'(T_NUM)) begin d = 8'h00; r = 2'b11; end
    else if (off == 12'd0) begin d = 8'hA5; r = 2'b00; end
    else                   begin d = m_regs[off[3:0]]; r = 2'b00; end
  endfunction

  function automatic logic [1:0] model_wr(input logic [11:0] a, input logic [7:0] d, input logic s);
    logic [11:0] off;
    off = a - T_BASE;
    if (off >= 12'(T_NUM)) return 2'b11;
    if (off == 12'd0)      return 2'b10;
    if (s) m_regs[off[3:0]] = d;
    return 2'b00;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ar_ready"}, bus.ar_ready, 0);
    check({tag, "_aw_ready"}, bus.aw_ready, 0);
    check({tag, "_w_ready"},  bus.w_ready,  0);
    check({tag, "_r_valid"},  bus.r_valid,  0);
    check({tag, "_b_valid"},  bus.b_valid,  0);
    check({tag, "_r_data"},   bus.r_data,   0);
    check({tag, "_r_resp"},   bus.r_resp,   0);
    check({tag, "_b_resp"},   bus.b_resp,   0);
  endtask

  task automatic read_txn(input string tag, input logic [11:0] a, input int hold, output int lat);
    exp_t e;
    exp_t got;
    int   n;
    e.tag = tag;
    model_rd(a, e.data, e.resp);
    sb.push_back(e);
    @(negedge aclk);
    bus.ar_addr = a; bus.ar_valid = 1'b1; bus.r_ready = 1'b0;
    lat = 0; n = 0;
    while (!bus.ar_ready && n < 20) begin @(negedge aclk); n++; lat++; end
    check({tag, "_ar_ready"}, bus.ar_ready, 1);
    @(negedge aclk); lat++;
    bus.ar_valid = 1'b0;
    n = 0;
    while (!bus.r_valid && n < 20) begin @(negedge aclk); n++; lat++; end
    check({tag, "_r_valid"}, bus.r_valid, 1);
    got = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      check({tag, "_hold_valid"}, bus.r_valid, 1);
      check({tag, "_hold_data"},  bus.r_data,  got.data);
    end
    check({got.tag, "_r_data"}, bus.r_data, got.data);
    check({got.tag, "_r_resp"}, bus.r_resp, got.resp);
    bus.r_ready = 1'b1;
    @(negedge aclk);
    bus.r_ready = 1'b0;
    check({tag, "_r_done"}, bus.r_valid, 0);
  endtask

  task automatic write_txn(input string tag, input logic [11:0] a, input logic [7:0] d, input logic s);
    exp_t e;
    exp_t got;
    int   n;
    e.tag = tag; e.data = 8'h00;
    e.resp = model_wr(a, d, s);
    sb.push_back(e);
    @(negedge aclk);
    bus.aw_addr = a; bus.aw_valid = 1'b1; bus.b_ready = 1'b0;
    n = 0;
    while (!bus.aw_ready && n < 20) begin @(negedge aclk); n++; end
    check({tag, "_aw_ready"}, bus.aw_ready, 1);
    @(negedge aclk);
    bus.aw_valid = 1'b0;
    check({tag, "_w_ready"}, bus.w_ready, 1);
    bus.w_data = d; bus.w_strb = s; bus.w_valid = 1'b1;
    @(negedge aclk);
    bus.w_valid = 1'b0;
    check({tag, "_b_valid"}, bus.b_valid, 1);
    got = sb.pop_front();
    check({got.tag, "_b_resp"}, bus.b_resp, got.resp);
    bus.b_ready = 1'b1;
    @(negedge aclk);
    bus.b_ready = 1'b0;
    check({tag, "_b_done"}, bus.b_valid, 0);
  endtask

  // Raise both address valids together, check the arbitration, then drop them
  // while the winning ready is up; the FSM must hold that state.
  task automatic dual(input string tag, input logic exp_read);
    @(negedge aclk);
    bus.ar_addr = 12'h005; bus.aw_addr = 12'h007;
    bus.ar_valid = 1'b1; bus.aw_valid = 1'b1;
    @(negedge aclk);
    check({tag, "_ar_ready"}, bus.ar_ready, exp_read);
    check({tag, "_aw_ready"}, bus.aw_ready, !exp_read);
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
    @(negedge aclk);
    check({tag, "_held_ar"}, bus.ar_ready, exp_read);
    check({tag, "_held_aw"}, bus.aw_ready, !exp_read);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.ar_addr = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
    bus.aw_addr = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0;  bus.w_strb = 1'b0;   bus.w_valid = 1'b0;
    bus.b_ready = 1'b0;
    model_reset();

    areset_n = 1'b0;
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    check_outputs_zero("reset");

    read_txn("rd_id", 12'h000, 0, lat);
    check("rd_latency", lat, 2);

    write_txn("wr5_3c", 12'h005, 8'h3C, 1'b1);
    read_txn("rd5_a", 12'h005, 0, lat);
    write_txn("wr5_strb0", 12'h005, 8'hFF, 1'b0);
    read_txn("rd5_b", 12'h005, 0, lat);

    write_txn("wr_id", 12'h000, 8'h12, 1'b1);
    read_txn("rd_id2", 12'h000, 0, lat);

    read_txn("rd_oor", 12'h010, 0, lat);
    write_txn("wr_oor", 12'hFFF, 8'h99, 1'b1);

    dual("dual1", 1'b1);
    read_txn("dual1_rd", 12'h005, 0, lat);
    dual("dual2", 1'b0);
    write_txn("dual2_wr", 12'h007, 8'h5A, 1'b1);
    dual("dual3", 1'b1);
    read_txn("dual3_rd", 12'h005, 0, lat);
    read_txn("rd7", 12'h007, 0, lat);

    read_txn("rd_hold", 12'h005, 5, lat);

    write_txn("wr3_11", 12'h003, 8'h11, 1'b1);
    write_txn("wr_id3", 12'h000, 8'h00, 1'b1);
    read_txn("rd3_pre", 12'h003, 0, lat);

    @(negedge aclk);
    bus.aw_addr = 12'h003; bus.aw_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.aw_ready && n < 20) begin @(negedge aclk); n++; end
    end
    check("abort_aw_ready", bus.aw_ready, 1);
    @(negedge aclk);
    bus.aw_valid = 1'b0;
    check("abort_w_ready", bus.w_ready, 1);
    bus.w_data = 8'h77; bus.w_strb = 1'b1; bus.w_valid = 1'b1;
    areset_n = 1'b0;
    @(negedge aclk);
    bus.w_valid = 1'b0;
    areset_n = 1'b1;
    model_reset();
    check_outputs_zero("abort");
    read_txn("rd3_post", 12'h003, 0, lat);
    read_txn("rd5_post", 12'h005, 0, lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
